// File: rtl/jelly_pulse_async_counter_pkg.sv
// ----------------------------------------------------------------------------
// jelly_pulse_async_counter_pkg
//   Shared Gray-code helpers for the pulse clock-domain-crossing counter.
//   The functions work on a fixed wide word; callers zero-extend their
//   counter into gray_word_t and truncate the result back to their own width.
//   Zero-extension is harmless for both directions of the conversion.
// ----------------------------------------------------------------------------
package jelly_pulse_async_counter_pkg;

  localparam int GRAY_WORD_W = 32;

  typedef logic [GRAY_WORD_W-1:0] gray_word_t;

  function automatic gray_word_t gray_from_bin(input gray_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic gray_word_t bin_from_gray(input gray_word_t gray);
    gray_word_t bin;
    bin[GRAY_WORD_W-1] = gray[GRAY_WORD_W-1];
    for (int i = GRAY_WORD_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/jelly_pulse_async_counter_unit.sv
// ----------------------------------------------------------------------------
// jelly_pulse_async_counter_unit
//   One channel of the pulse CDC counter.
//   s side: write counter (binary + registered Gray), synchronized read count,
//           full / sticky overflow flags.
//   m side: read counter (binary + registered Gray), synchronized write count,
//           pending count and valid/ready consumption.
// Ports
//   s_reset, s_clk       source reset (sync, active-high) and clock
//   s_pulse              one event when high
//   s_overflow_clear     clears s_overflow (a same-cycle set wins)
//   s_full, s_overflow   no free capacity / a pulse was dropped
//   m_reset, m_clk       destination reset (sync, active-high) and clock
//   m_valid, m_ready     one event consumed per valid & ready
//   m_pending            outstanding events as seen from the m side
// ----------------------------------------------------------------------------
module jelly_pulse_async_counter_unit
  import jelly_pulse_async_counter_pkg::*;
#(
  parameter int ASYNC       = 1,
  parameter int COUNT_WIDTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   s_reset,
  input  logic                   s_clk,
  input  logic                   s_pulse,
  input  logic                   s_overflow_clear,
  output logic                   s_full,
  output logic                   s_overflow,
  input  logic                   m_reset,
  input  logic                   m_clk,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [COUNT_WIDTH-1:0] m_pending
);

  localparam logic [COUNT_WIDTH-1:0] CAPACITY = '1;

  // s domain
  logic [COUNT_WIDTH-1:0] r_wcnt;
  logic [COUNT_WIDTH-1:0] r_wgray;
  logic                   r_overflow;
  logic [COUNT_WIDTH-1:0] w_wcnt_next;
  logic [COUNT_WIDTH-1:0] w_rcnt_s;     // read count as visible to the s side
  logic [COUNT_WIDTH-1:0] w_used;
  logic                   w_s_accept;

  // m domain
  logic [COUNT_WIDTH-1:0] r_rcnt;
  logic [COUNT_WIDTH-1:0] r_rgray;
  logic [COUNT_WIDTH-1:0] w_rcnt_next;
  logic [COUNT_WIDTH-1:0] w_wcnt_m;     // write count as visible to the m side
  logic                   w_m_accept;

  // ---------------------------------------------------------------- s side
  assign w_used      = r_wcnt - w_rcnt_s;
  assign s_full      = (w_used == CAPACITY);
  assign w_s_accept  = s_pulse & ~s_full;
  assign w_wcnt_next = r_wcnt + 1'b1;
  assign s_overflow  = r_overflow;

  always_ff @(posedge s_clk) begin
    if (s_reset) begin
      r_wcnt     <= '0;
      r_wgray    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_s_accept) begin
        r_wcnt  <= w_wcnt_next;
        r_wgray <= COUNT_WIDTH'(gray_from_bin(gray_word_t'(w_wcnt_next)));
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (s_pulse && s_full) begin
        r_overflow <= 1'b1;
      end else if (s_overflow_clear) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- m side
  assign m_pending   = w_wcnt_m - r_rcnt;
  assign m_valid     = |m_pending;
  assign w_m_accept  = m_valid & m_ready;
  assign w_rcnt_next = r_rcnt + 1'b1;

  always_ff @(posedge m_clk) begin
    if (m_reset) begin
      r_rcnt  <= '0;
      r_rgray <= '0;
    end else if (w_m_accept) begin
      r_rcnt  <= w_rcnt_next;
      r_rgray <= COUNT_WIDTH'(gray_from_bin(gray_word_t'(w_rcnt_next)));
    end
  end

  // ---------------------------------------------------------- crossings
  if (ASYNC != 0) begin : g_async
    // Gray source registers feed the first stages directly.
    (* ASYNC_REG = "true" *) logic [COUNT_WIDTH-1:0] r_rsync_ff0;
    logic [COUNT_WIDTH-1:0] r_rsync_ff [1:SYNC_STAGES-1];
    (* ASYNC_REG = "true" *) logic [COUNT_WIDTH-1:0] r_wsync_ff0;
    logic [COUNT_WIDTH-1:0] r_wsync_ff [1:SYNC_STAGES-1];
    logic [COUNT_WIDTH-1:0] r_wsync_bin;

    always_ff @(posedge s_clk) begin
      if (s_reset) begin
        r_rsync_ff0 <= '0;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          r_rsync_ff[i] <= '0;
        end
      end else begin
        r_rsync_ff0   <= r_rgray;
        r_rsync_ff[1] <= r_rsync_ff0;
        for (int i = 2; i < SYNC_STAGES; i++) begin
          r_rsync_ff[i] <= r_rsync_ff[i-1];
        end
      end
    end

    assign w_rcnt_s =
        COUNT_WIDTH'(bin_from_gray(gray_word_t'(r_rsync_ff[SYNC_STAGES-1])));

    always_ff @(posedge m_clk) begin
      if (m_reset) begin
        r_wsync_ff0 <= '0;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          r_wsync_ff[i] <= '0;
        end
        r_wsync_bin <= '0;
      end else begin
        r_wsync_ff0   <= r_wgray;
        r_wsync_ff[1] <= r_wsync_ff0;
        for (int i = 2; i < SYNC_STAGES; i++) begin
          r_wsync_ff[i] <= r_wsync_ff[i-1];
        end
        r_wsync_bin <=
            COUNT_WIDTH'(bin_from_gray(gray_word_t'(r_wsync_ff[SYNC_STAGES-1])));
      end
    end

    assign w_wcnt_m = r_wsync_bin;
  end else begin : g_sync
    // Single clock: both sides read the binary counters directly, so s_full
    // is exact and m_valid follows an accepted pulse by one cycle.
    logic w_unused_gray;
    assign w_unused_gray = ^{r_wgray, r_rgray};
    assign w_rcnt_s      = r_rcnt;
    assign w_wcnt_m      = r_wcnt;
  end

endmodule

// File: rtl/jelly_pulse_async_counter.sv
// ----------------------------------------------------------------------------
// jelly_pulse_async_counter
//   Multi-channel lossless pulse clock-domain crossing. Each channel counts
//   s_pulse events in the s_clk domain and presents them in the m_clk domain
//   as a valid/ready stream, one event per handshake.
// Ports (per channel bit / slice)
//   s_reset, s_clk         source reset (sync, active-high) and clock
//   s_pulse                event input
//   s_overflow_clear       clears the matching s_overflow bit
//   s_full                 no free capacity (conservative when ASYNC=1)
//   s_overflow             sticky: a pulse was dropped while full
//   m_reset, m_clk         destination reset (sync, active-high) and clock
//   m_valid, m_ready       event handshake
//   m_pending              COUNT_WIDTH-bit outstanding count per channel
// ----------------------------------------------------------------------------
module jelly_pulse_async_counter
  import jelly_pulse_async_counter_pkg::*;
#(
  parameter int ASYNC       = 1,
  parameter int CHANNELS    = 1,
  parameter int COUNT_WIDTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            s_reset,
  input  logic                            s_clk,
  input  logic [CHANNELS-1:0]             s_pulse,
  input  logic [CHANNELS-1:0]             s_overflow_clear,
  output logic [CHANNELS-1:0]             s_full,
  output logic [CHANNELS-1:0]             s_overflow,
  input  logic                            m_reset,
  input  logic                            m_clk,
  output logic [CHANNELS-1:0]             m_valid,
  input  logic [CHANNELS-1:0]             m_ready,
  output logic [CHANNELS*COUNT_WIDTH-1:0] m_pending
);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    jelly_pulse_async_counter_unit #(
      .ASYNC       (ASYNC),
      .COUNT_WIDTH (COUNT_WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_unit (
      .s_reset          (s_reset),
      .s_clk            (s_clk),
      .s_pulse          (s_pulse[ch]),
      .s_overflow_clear (s_overflow_clear[ch]),
      .s_full           (s_full[ch]),
      .s_overflow       (s_overflow[ch]),
      .m_reset          (m_reset),
      .m_clk            (m_clk),
      .m_valid          (m_valid[ch]),
      .m_ready          (m_ready[ch]),
      .m_pending        (m_pending[ch*COUNT_WIDTH +: COUNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_jelly_pulse_async_counter.sv
// Directed bench: a 2-channel asynchronous instance and a 1-channel
// single-clock instance sharing s_clk.
module tb_jelly_pulse_async_counter;

  int s_half = 5;
  int m_half = 15;

  logic       s_clk = 1'b0;
  logic       m_clk = 1'b0;
  logic       s_reset = 1'b1;
  logic       m_reset = 1'b1;
  logic [1:0] s_pulse = '0;
  logic [1:0] s_overflow_clear = '0;
  logic [1:0] s_full;
  logic [1:0] s_overflow;
  logic [1:0] m_valid;
  logic [1:0] m_ready = '0;
  logic [7:0] m_pending;

  logic [0:0] y_pulse = '0;
  logic [0:0] y_clr = '0;
  logic [0:0] y_full;
  logic [0:0] y_ovf;
  logic [0:0] y_valid;
  logic [0:0] y_ready = '0;
  logic [3:0] y_pending;

  int checks = 0;
  int errors = 0;
  int acc [2] = '{0, 0};   // pulses driven while s_full was low
  int hs  [2] = '{0, 0};   // m handshakes
  int rdy_mode = 0;        // 0: ready low, 1: ready high, 2: random
  int over_cnt = 0;        // m_pending ever above true outstanding

  always begin #(s_half); s_clk = ~s_clk; end
  always begin #(m_half); m_clk = ~m_clk; end

  jelly_pulse_async_counter #(
    .ASYNC       (1),
    .CHANNELS    (2),
    .COUNT_WIDTH (4),
    .SYNC_STAGES (2)
  ) u_dut (
    .s_reset          (s_reset),
    .s_clk            (s_clk),
    .s_pulse          (s_pulse),
    .s_overflow_clear (s_overflow_clear),
    .s_full           (s_full),
    .s_overflow       (s_overflow),
    .m_reset          (m_reset),
    .m_clk            (m_clk),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_pending        (m_pending)
  );

  jelly_pulse_async_counter #(
    .ASYNC       (0),
    .CHANNELS    (1),
    .COUNT_WIDTH (4),
    .SYNC_STAGES (2)
  ) u_dut_sync (
    .s_reset          (s_reset),
    .s_clk            (s_clk),
    .s_pulse          (y_pulse),
    .s_overflow_clear (y_clr),
    .s_full           (y_full),
    .s_overflow       (y_ovf),
    .m_reset          (s_reset),
    .m_clk            (s_clk),
    .m_valid          (y_valid),
    .m_ready          (y_ready),
    .m_pending        (y_pending)
  );

  // m-side consumer and scoreboard: ready is set mid-cycle, so valid&ready
  // seen here is exactly the handshake at the following rising edge.
  always @(negedge m_clk) begin
    case (rdy_mode)
      0:       m_ready = 2'b00;
      1:       m_ready = 2'b11;
      default: m_ready = 2'($urandom_range(0, 3));
    endcase
    for (int ch = 0; ch < 2; ch++) begin
      if (int'(m_pending[ch*4 +: 4]) > acc[ch] - hs[ch]) over_cnt++;
      if (m_valid[ch] && m_ready[ch]) hs[ch]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_s(input logic [1:0] p, input logic [1:0] clr);
    @(negedge s_clk);
    for (int ch = 0; ch < 2; ch++) begin
      if (p[ch] && !s_full[ch]) acc[ch]++;
    end
    s_pulse          = p;
    s_overflow_clear = clr;
  endtask

  initial begin
    int bad;
    int peak;
    int h0;
    int h1;
    int a0;

    // 1: reset
    repeat (12) @(negedge m_clk);
    @(negedge s_clk);
    s_reset = 1'b0;
    @(negedge m_clk);
    m_reset = 1'b0;
    check("rst_s_full", 32'(s_full), 0);
    check("rst_s_overflow", 32'(s_overflow), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_pending", 32'(m_pending), 0);
    check("rst_sync_valid", 32'(y_valid), 0);
    bad = 0;
    repeat (100) begin
      @(negedge m_clk);
      if (m_valid != 2'b00) bad++;
    end
    check("rst_idle_valid", 32'(bad), 0);

    // 2: five back-to-back pulses on ch0, consumer always ready
    rdy_mode = 1;
    h0 = hs[0];
    h1 = hs[1];
    a0 = acc[0];
    repeat (5) drive_s(2'b01, 2'b00);
    drive_s(2'b00, 2'b00);
    peak = 0;
    repeat (40) begin
      @(negedge m_clk);
      if (int'(m_pending[3:0]) > peak) peak = int'(m_pending[3:0]);
    end
    check("burst_accepted", 32'(acc[0] - a0), 5);
    check("burst_handshakes", 32'(hs[0] - h0), 5);
    check("burst_peak_le5", 32'(peak <= 5), 1);
    check("burst_ch1_idle", 32'(hs[1] - h1), 0);
    check("burst_valid_done", 32'(m_valid), 0);

    // 3: fill ch0 with consumer stalled, overflow and clear
    rdy_mode = 0;
    repeat (10) @(negedge s_clk);
    a0 = acc[0];
    repeat (15) drive_s(2'b01, 2'b00);
    drive_s(2'b00, 2'b00);
    check("fill_full_at15", 32'(s_full[0]), 1);
    check("fill_no_ovf_at15", 32'(s_overflow[0]), 0);
    repeat (5) drive_s(2'b01, 2'b00);
    drive_s(2'b00, 2'b00);
    check("fill_accepted", 32'(acc[0] - a0), 15);
    check("fill_overflow", 32'(s_overflow), 32'h1);
    repeat (12) @(negedge m_clk);
    check("fill_pending15", 32'(m_pending[3:0]), 15);
    check("fill_valid", 32'(m_valid[0]), 1);
    drive_s(2'b01, 2'b01);
    drive_s(2'b00, 2'b00);
    check("ovf_set_beats_clear", 32'(s_overflow[0]), 1);
    drive_s(2'b00, 2'b01);
    drive_s(2'b00, 2'b00);
    check("ovf_cleared", 32'(s_overflow[0]), 0);
    rdy_mode = 1;
    repeat (40) @(negedge m_clk);
    check("fill_drained_hs", 32'(hs[0]), 32'(acc[0]));
    check("fill_drained_pend", 32'(m_pending), 0);
    repeat (10) @(negedge s_clk);
    check("fill_not_full", 32'(s_full), 0);

    // 6: single-clock latency
    @(negedge s_clk);
    y_pulse = 1'b1;
    check("sync_valid_c3", 32'(y_valid), 0);
    @(negedge s_clk);
    y_pulse = 1'b0;
    y_ready = 1'b1;
    check("sync_valid_c4", 32'(y_valid), 1);
    check("sync_pending_c4", 32'(y_pending), 1);
    @(negedge s_clk);
    y_ready = 1'b0;
    check("sync_valid_c5", 32'(y_valid), 0);

    // 5: handshake and arrival in the same cycle
    @(negedge s_clk); y_pulse = 1'b1;
    @(negedge s_clk); y_pulse = 1'b1;
    @(negedge s_clk); y_pulse = 1'b0;
    check("same_pre_pending", 32'(y_pending), 2);
    @(negedge s_clk); y_pulse = 1'b1; y_ready = 1'b1;
    @(negedge s_clk); y_pulse = 1'b0; y_ready = 1'b0;
    check("same_pending", 32'(y_pending), 2);
    check("same_valid", 32'(y_valid), 1);
    @(negedge s_clk); y_ready = 1'b1;
    @(negedge s_clk);
    check("same_after_one", 32'(y_pending), 1);
    @(negedge s_clk); y_ready = 1'b0;
    check("same_drained", 32'(y_pending), 0);

    // single clock: exact full at capacity
    repeat (15) begin @(negedge s_clk); y_pulse = 1'b1; end
    @(negedge s_clk); y_pulse = 1'b0;
    check("sync_full", 32'(y_full), 1);
    check("sync_pending15", 32'(y_pending), 15);
    y_ready = 1'b1;
    repeat (15) @(negedge s_clk);
    y_ready = 1'b0;
    check("sync_empty", 32'(y_valid), 0);
    check("sync_not_full", 32'(y_full), 0);

    // 4: random traffic across wraps, s fast then m fast
    rdy_mode = 2;
    repeat (500) drive_s(2'($urandom_range(0, 3)), 2'b00);
    s_half = 15;
    m_half = 5;
    repeat (500) drive_s(2'($urandom_range(0, 3)), 2'b00);
    drive_s(2'b00, 2'b00);
    rdy_mode = 1;
    repeat (100) @(negedge m_clk);
    check("rand_ch0_count", 32'(hs[0]), 32'(acc[0]));
    check("rand_ch1_count", 32'(hs[1]), 32'(acc[1]));
    check("rand_no_overstate", 32'(over_cnt), 0);
    check("rand_valid_done", 32'(m_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
